// File: rtl/mem_arbiter_pkg.sv
// Shared constants, state types and the tie-break rule for the CPU/VGA memory arbiter.
package mem_arbiter_pkg;

    localparam int unsigned DefWordSize = 32;
    localparam int unsigned DefMemAw    = 9;
    localparam int unsigned DefVgaBurst = 16;

    // mem_ctrl source select
    localparam logic SRC_CPU = 1'b1;
    localparam logic SRC_VGA = 1'b0;

    typedef enum logic [2:0] {
        StIdle,
        StCpuIssue,
        StCpuResp,
        StVgaBurst,
        StVgaDrain
    } arb_state_e;

    typedef enum logic {
        GrantCpu,
        GrantVga
    } grant_e;

    // CPU wins when it asks alone, or on a tie when VGA held the previous grant.
    function automatic logic cpu_wins(input logic cpu_req, input logic vga_req,
                                      input grant_e last_grant);
        return cpu_req && (!vga_req || (last_grant == GrantVga));
    endfunction

endpackage

// File: rtl/mem_arbiter_vga_burst_gen.sv
// VGA burst address counter plus the one-cycle delay that aligns idx/valid/done with RAM data.
module mem_arbiter_vga_burst_gen #(
    parameter int unsigned MEM_AW    = 9,
    parameter int unsigned VGA_BURST = 16
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         start,
    input  logic                         active,
    input  logic [MEM_AW-1:0]            base,
    output logic [MEM_AW-1:0]            addr,
    output logic                         last,
    output logic                         valid,
    output logic [$clog2(VGA_BURST)-1:0] idx,
    output logic                         done
);

    localparam int unsigned IdxW = $clog2(VGA_BURST);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(VGA_BURST - 1);

    logic [MEM_AW-1:0] addr_q, addr_d;
    logic [IdxW-1:0]   cnt_q, cnt_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;

    assign last = active && (cnt_q == LastIdx);

    // Load base at grant, then step address and word count once per issue cycle.
    always_comb begin
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        if (start) begin
            addr_d = base;
            cnt_d  = '0;
        end else if (active) begin
            addr_d = addr_q + MEM_AW'(1);   // wraps mod RAM size
            cnt_d  = cnt_q + IdxW'(1);
        end
        valid_d = active;
        idx_d   = cnt_q;
        done_d  = last;
    end

    // Counter and data-side pipeline state; reset abandons any burst in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_q  <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign addr  = addr_q;
    assign valid = valid_q;
    assign idx   = idx_q;
    assign done  = done_q;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single-port RAM (via mem_ctrl) between CPU word accesses and VGA read bursts.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned WORD_SIZE = DefWordSize,
    parameter int unsigned MEM_AW    = DefMemAw,
    parameter int unsigned VGA_BURST = DefVgaBurst
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         cpu_req,
    input  logic                         cpu_we,
    input  logic [WORD_SIZE-1:0]         cpu_addr,
    input  logic [WORD_SIZE-1:0]         cpu_wd,
    output logic                         cpu_ready,
    output logic [WORD_SIZE-1:0]         cpu_rdata,
    input  logic                         vga_req,
    input  logic [MEM_AW-1:0]            vga_base,
    output logic                         vga_ack,
    output logic                         vga_valid,
    output logic [$clog2(VGA_BURST)-1:0] vga_idx,
    output logic [WORD_SIZE-1:0]         vga_data,
    output logic                         vga_done,
    output logic                         mem_src,
    output logic [WORD_SIZE-1:0]         mem_cpu_addr,
    output logic [MEM_AW-1:0]            mem_vga_addr,
    output logic                         mem_cpu_we,
    output logic [WORD_SIZE-1:0]         mem_cpu_wd,
    input  logic [WORD_SIZE-1:0]         mem_rd
);

    arb_state_e           state_q, state_d;
    grant_e               last_grant_q, last_grant_d;
    logic                 mem_src_q, mem_src_d;
    logic                 mem_cpu_we_q, mem_cpu_we_d;
    logic [WORD_SIZE-1:0] mem_cpu_addr_q, mem_cpu_addr_d;
    logic [WORD_SIZE-1:0] mem_cpu_wd_q, mem_cpu_wd_d;
    logic                 cpu_ready_q, cpu_ready_d;
    logic                 vga_ack_q, vga_ack_d;
    logic                 grant_cpu, grant_vga;
    logic                 burst_active, burst_last;

    assign burst_active = (state_q == StVgaBurst);

    // Arbitration, next state, and outputs registered one cycle ahead of the state they belong to.
    always_comb begin
        grant_cpu    = (state_q == StIdle) && cpu_wins(cpu_req, vga_req, last_grant_q);
        grant_vga    = (state_q == StIdle) && vga_req && !grant_cpu;
        state_d      = state_q;
        last_grant_d = last_grant_q;
        unique case (state_q)
            StIdle: begin
                if (grant_cpu) begin
                    state_d      = StCpuIssue;
                    last_grant_d = GrantCpu;
                end else if (grant_vga) begin
                    state_d      = StVgaBurst;
                    last_grant_d = GrantVga;
                end
            end
            StCpuIssue: state_d = StCpuResp;
            StCpuResp:  state_d = StIdle;
            StVgaBurst: if (burst_last) state_d = StVgaDrain;
            StVgaDrain: state_d = StIdle;
            default:    state_d = StIdle;
        endcase
        // CPU owns the RAM only during the issue cycle, which always follows its grant.
        mem_src_d      = grant_cpu ? SRC_CPU : SRC_VGA;
        mem_cpu_we_d   = grant_cpu && cpu_we;
        mem_cpu_addr_d = grant_cpu ? cpu_addr : mem_cpu_addr_q;
        mem_cpu_wd_d   = grant_cpu ? cpu_wd : mem_cpu_wd_q;
        cpu_ready_d    = (state_q == StCpuIssue);
        vga_ack_d      = grant_vga;
    end

    // FSM state and registered outputs; async reset drops everything and forgets in-flight work.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q        <= StIdle;
            last_grant_q   <= GrantCpu;
            mem_src_q      <= SRC_VGA;
            mem_cpu_we_q   <= 1'b0;
            mem_cpu_addr_q <= '0;
            mem_cpu_wd_q   <= '0;
            cpu_ready_q    <= 1'b0;
            vga_ack_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            mem_src_q      <= mem_src_d;
            mem_cpu_we_q   <= mem_cpu_we_d;
            mem_cpu_addr_q <= mem_cpu_addr_d;
            mem_cpu_wd_q   <= mem_cpu_wd_d;
            cpu_ready_q    <= cpu_ready_d;
            vga_ack_q      <= vga_ack_d;
        end
    end

    mem_arbiter_vga_burst_gen #(
        .MEM_AW    (MEM_AW),
        .VGA_BURST (VGA_BURST)
    ) u_burst_gen (
        .clk    (clk),
        .resetn (resetn),
        .start  (grant_vga),
        .active (burst_active),
        .base   (vga_base),
        .addr   (mem_vga_addr),
        .last   (burst_last),
        .valid  (vga_valid),
        .idx    (vga_idx),
        .done   (vga_done)
    );

    assign mem_src      = mem_src_q;
    assign mem_cpu_we   = mem_cpu_we_q;
    assign mem_cpu_addr = mem_cpu_addr_q;
    assign mem_cpu_wd   = mem_cpu_wd_q;
    assign cpu_ready    = cpu_ready_q;
    assign vga_ack      = vga_ack_q;
    // RAM data is routed to whichever requester owns the response cycle; zero otherwise.
    assign cpu_rdata    = cpu_ready_q ? mem_rd : '0;
    assign vga_data     = vga_valid ? mem_rd : '0;

endmodule
